// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port synchronous-read
// memory. Port 0 is the CPU, port 1 a loader/debug master. Every access runs
// IDLE -> ISSUE -> RESP, so one access completes every three cycles.
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  // port 0 (CPU)
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  // port 1 (loader / debug)
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  // memory side
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // status
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    op_we_q, op_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  // Per-port request views, indexed by port number so the winner can be
  // selected with a single index instead of duplicated muxes.
  logic [1:0]              req_vec;
  logic [1:0]              we_vec;
  logic [ADDR_WIDTH-1:0]   addr_vec  [2];
  logic [DATA_WIDTH-1:0]   wdata_vec [2];
  logic [1:0]              ack_vec;
  logic [DATA_WIDTH-1:0]   rdata_vec [2];

  logic                    any_req;
  logic                    grant_sel;

  assign req_vec   = {m1_req, m0_req};
  assign we_vec    = {m1_we, m0_we};
  assign addr_vec[0]  = m0_addr;
  assign addr_vec[1]  = m1_addr;
  assign wdata_vec[0] = m0_wdata;
  assign wdata_vec[1] = m1_wdata;
  assign any_req   = |req_vec;

  // Winner for the next grant; only meaningful while any_req is high.
  always_comb begin
    grant_sel = 1'b0;
    unique case (req_vec)
      2'b01: grant_sel = 1'b0;
      2'b10: grant_sel = 1'b1;
      2'b11: begin
        if (m1_lock && last_grant_q) begin
          // port 1 holds an active burst lock: it keeps the memory
          grant_sel = 1'b1;
        end else if (FIXED_PRIO) begin
          grant_sel = 1'b1;
        end else begin
          // round-robin: whoever did not go last wins the tie
          grant_sel = ~last_grant_q;
        end
      end
      default: grant_sel = 1'b0;
    endcase
  end

  // State and datapath registers, cleared asynchronously so an abort drops
  // the write strobe immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_we_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_we_q      <= op_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state logic: grant in IDLE, strobe memory in ISSUE, answer in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_we_d      = op_we_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = ISSUE;
          last_grant_d = grant_sel;
          op_we_d      = we_vec[grant_sel];
          mem_addr_d   = addr_vec[grant_sel];
          mem_we_d     = we_vec[grant_sel];
          mem_wdata_d  = wdata_vec[grant_sel];
        end
      end
      ISSUE: begin
        // write strobe lasts exactly the ISSUE cycle
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: only the owner sees ack/rdata, and only during RESP.
  always_comb begin
    busy = (state_q != IDLE);
    for (int i = 0; i < 2; i++) begin
      ack_vec[i]   = 1'b0;
      rdata_vec[i] = '0;
    end
    if (state_q == RESP) begin
      ack_vec[last_grant_q] = 1'b1;
      if (!op_we_q) begin
        rdata_vec[last_grant_q] = mem_rdata;
      end
    end
  end

  assign m0_ack    = ack_vec[0];
  assign m1_ack    = ack_vec[1];
  assign m0_rdata  = rdata_vec[0];
  assign m1_rdata  = rdata_vec[1];
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign owner     = last_grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a scoreboard of
// expected acknowledgements (port, read data, cycle) per DUT instance.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  // DUT 0: round-robin
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_ack, m1_ack, mem_we, busy, owner;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem0 [0:(1<<AW)-1];

  // DUT 1: fixed priority
  logic          p_m0_req = 0, p_m0_we = 0, p_m1_req = 0, p_m1_we = 0, p_m1_lock = 0;
  logic [AW-1:0] p_m0_addr = '0, p_m1_addr = '0;
  logic [DW-1:0] p_m0_wdata = '0, p_m1_wdata = '0;
  logic          p_m0_ack, p_m1_ack, p_mem_we, p_busy, p_owner;
  logic [DW-1:0] p_m0_rdata, p_m1_rdata, p_mem_wdata;
  logic [AW-1:0] p_mem_addr;
  logic [DW-1:0] p_mem_rdata = '0;
  logic [DW-1:0] mem1 [0:(1<<AW)-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1'b0)) dut (
    .CLK(clk), .RST(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1'b1)) dut_fp (
    .CLK(clk), .RST(rst),
    .m0_req(p_m0_req), .m0_we(p_m0_we), .m0_addr(p_m0_addr), .m0_wdata(p_m0_wdata),
    .m0_ack(p_m0_ack), .m0_rdata(p_m0_rdata),
    .m1_req(p_m1_req), .m1_we(p_m1_we), .m1_addr(p_m1_addr), .m1_wdata(p_m1_wdata),
    .m1_lock(p_m1_lock), .m1_ack(p_m1_ack), .m1_rdata(p_m1_rdata),
    .mem_addr(p_mem_addr), .mem_we(p_mem_we), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata), .busy(p_busy), .owner(p_owner)
  );

  // synchronous-read memory models, one per DUT
  always @(posedge clk) begin
    if (mem_we) mem0[mem_addr] <= mem_wdata;
    mem_rdata <= mem0[mem_addr];
  end

  always @(posedge clk) begin
    if (p_mem_we) mem1[p_mem_addr] <= p_mem_wdata;
    p_mem_rdata <= mem1[p_mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop and compare one expected ack whenever a DUT acknowledges.
  task automatic score(input int which, input logic a0, input logic a1,
                       input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    exp_t e;
    logic have;
    logic p;
    if (!(a0 || a1)) return;
    p = a1;
    check($sformatf("dut%0d_single_ack", which), 32'(a0 & a1), 32'd0);
    have = (which == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
    check($sformatf("dut%0d_ack_expected", which), 32'(have), 32'd1);
    if (!have) return;
    if (which == 0) e = sb0.pop_front();
    else            e = sb1.pop_front();
    $display("txn dut%0d port%0d rdata=0x%04h cycle=%0d", which, p, p ? r1 : r0, cyc);
    check($sformatf("dut%0d_ack_port", which), 32'(p), 32'(e.port));
    check($sformatf("dut%0d_ack_cycle", which), 32'(cyc), 32'(e.cyc));
    check($sformatf("dut%0d_ack_rdata", which), 32'(p ? r1 : r0), 32'(e.data));
    check($sformatf("dut%0d_other_rdata", which), 32'(p ? r0 : r1), 32'd0);
  endtask

  always @(negedge clk) score(0, m0_ack, m1_ack, m0_rdata, m1_rdata);
  always @(negedge clk) score(1, p_m0_ack, p_m1_ack, p_m0_rdata, p_m1_rdata);

  task automatic check_reset_state();
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
    check("rst_rdata", 32'({m1_rdata, m0_rdata}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_fp_busy", 32'(p_busy), 32'd0);
    check("rst_fp_owner", 32'(p_owner), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_reset_state();
    tick(2);
    rst = 1'b0;
    tick(1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_owner", 32'(owner), 32'd1);
  endtask

  // One isolated access on DUT 0, checking the memory side cycle by cycle.
  task automatic single(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    int c;
    c = cyc;
    if (port) begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end
    sb0.push_back('{port, exp_rd, c + 2});
    tick(1);
    check("issue_addr", 32'(mem_addr), 32'(addr));
    check("issue_we", 32'(mem_we), 32'(we));
    check("issue_wdata", 32'(mem_wdata), 32'(wdata));
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_owner", 32'(owner), 32'(port));
    tick(1);
    check("resp_we", 32'(mem_we), 32'd0);
    check("resp_busy", 32'(busy), 32'd1);
    tick(1);
    if (port) m1_req = 1'b0;
    else      m0_req = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int c;
    tick(1);
    pulse_reset();

    // loader preloads word 5, CPU reads it back
    single(1'b1, 1'b1, 16'd5, 16'h1234, 16'h0000);
    single(1'b0, 1'b0, 16'd5, 16'h0000, 16'h1234);

    // loader write then CPU read of the same word
    single(1'b1, 1'b1, 16'd31, 16'h6002, 16'h0000);
    single(1'b0, 1'b0, 16'd31, 16'h0000, 16'h6002);

    // round-robin with both ports requesting continuously
    pulse_reset();
    c = cyc;
    m0_we = 0; m0_addr = 16'd5;  m0_req = 1'b1;
    m1_we = 0; m1_addr = 16'd31; m1_req = 1'b1;
    sb0.push_back('{1'b0, 16'h1234, c + 2});
    sb0.push_back('{1'b1, 16'h6002, c + 5});
    sb0.push_back('{1'b0, 16'h1234, c + 8});
    sb0.push_back('{1'b1, 16'h6002, c + 11});
    for (int k = 0; k < 4; k++) begin
      tick((k == 0) ? 1 : 3);
      check("rr_owner", 32'(owner), 32'(k % 2));
    end
    tick(2);
    m0_req = 1'b0; m1_req = 1'b0;

    // locked burst of three port-1 writes while port 0 waits
    pulse_reset();
    c = cyc;
    m0_we = 0; m0_addr = 16'd5; m0_req = 1'b1;
    m1_we = 1; m1_addr = 16'd40; m1_wdata = 16'h0A0A; m1_lock = 1'b1; m1_req = 1'b1;
    sb0.push_back('{1'b1, 16'h0000, c + 2});
    sb0.push_back('{1'b1, 16'h0000, c + 5});
    sb0.push_back('{1'b1, 16'h0000, c + 8});
    sb0.push_back('{1'b0, 16'h1234, c + 11});
    tick(8);
    m1_lock = 1'b0;
    tick(2);
    m1_req = 1'b0;
    check("lock_release_owner", 32'(owner), 32'd0);
    tick(2);
    m0_req = 1'b0;
    tick(1);
    check("lock_mem_word", 32'(mem0[40]), 32'h0A0A);

    // reset during the ISSUE cycle of a port-0 write
    pulse_reset();
    m0_we = 1; m0_addr = 16'd50; m0_wdata = 16'hBEEF; m0_req = 1'b1;
    tick(1);
    check("abort_issue_we", 32'(mem_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_we_drop", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_owner", 32'(owner), 32'd1);
    check("abort_ack", 32'(m0_ack), 32'd0);
    m0_req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("abort_post_busy", 32'(busy), 32'd0);
    check("abort_post_owner", 32'(owner), 32'd1);
    single(1'b0, 1'b0, 16'd5, 16'h0000, 16'h1234);

    // fixed priority: port 1 takes every tie until it stops requesting
    c = cyc;
    p_m0_we = 1; p_m0_addr = 16'd7; p_m0_wdata = 16'h0707; p_m0_req = 1'b1;
    p_m1_we = 1; p_m1_addr = 16'd8; p_m1_wdata = 16'h0808; p_m1_req = 1'b1;
    sb1.push_back('{1'b1, 16'h0000, c + 2});
    sb1.push_back('{1'b1, 16'h0000, c + 5});
    sb1.push_back('{1'b1, 16'h0000, c + 8});
    sb1.push_back('{1'b0, 16'h0000, c + 11});
    tick(9);
    p_m1_req = 1'b0;
    tick(3);
    p_m0_req = 1'b0;
    tick(2);
    check("fp_mem_word7", 32'(mem1[7]), 32'h0707);
    check("fp_mem_word8", 32'(mem1[8]), 32'h0808);

    tick(3);
    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
